ikaopll_lfo_gen: RTL

Parametrised successor of the OPLL LFO, implemented as parallel counters rather than a bit-serial shift register. It generates the vibrato (PM) index and the tremolo (AM) attenuation for the operator pipeline. It adds a selectable rate multiplier, triangle/sawtooth AM shape, a deep/shallow AM depth select and a synchronous LFO restart. It sits beside the timing generator, and its outputs feed the phase generator (PM) and the envelope generator (AM).

---
 rtl/ikaopll_lfo_gen_if.sv | 40 ++++
 rtl/ikaopll_lfo_gen.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ikaopll_lfo_gen_if.sv
// LFO control/status bundle.
//   master side (timing generator / register file) drives the enables, strobes and mode bits;
//   slave side (ikaopll_lfo_gen) returns the PM index and the AM attenuation.
//   phi1_pcen_n  active-low enable for the AM output latch
//   phi1_ncen_n  active-low enable for all counters
//   cycle_00     AM output latch strobe
//   cycle_21     LFO tick strobe
//   test         [1] hold/clear, [3] fast step
//   rate_sel     rate multiplier x1/x2/x4/x8
//   am_mode      0 triangle, 1 sawtooth
//   am_deep      1 deep, 0 shallow
//   sync         synchronous restart
//   pmval        vibrato index
//   amval        tremolo attenuation (registered)
interface ikaopll_lfo_gen_if #(
  parameter int unsigned PM_W = 3,
  parameter int unsigned AM_W = 4
);
  logic            phi1_pcen_n;
  logic            phi1_ncen_n;
  logic            cycle_00;
  logic            cycle_21;
  logic [3:0]      test;
  logic [1:0]      rate_sel;
  logic            am_mode;
  logic            am_deep;
  logic            sync;
  logic [PM_W-1:0] pmval;
  logic [AM_W-1:0] amval;

  modport master (
    output phi1_pcen_n, phi1_ncen_n, cycle_00, cycle_21, test, rate_sel, am_mode, am_deep, sync,
    input  pmval, amval
  );

  modport slave (
    input  phi1_pcen_n, phi1_ncen_n, cycle_00, cycle_21, test, rate_sel, am_mode, am_deep, sync,
    output pmval, amval
  );
endinterface

// File: rtl/ikaopll_lfo_gen.sv
// OPLL-style LFO built from parallel counters.
// Produces the vibrato index (pmval, straight from the PM counter) and the tremolo
// attenuation (amval, latched on cycle_00). Supports a rate multiplier, triangle/sawtooth
// AM shape, deep/shallow AM depth and a synchronous restart.
//   emuclk_i  master clock, all state on posedge
//   rst_i     asynchronous active-high reset
//   bus       ikaopll_lfo_gen_if slave modport (enables, strobes, modes, outputs)
module ikaopll_lfo_gen #(
  parameter int unsigned PRESC_W  = 6,
  parameter int unsigned PM_DIV_W = 4,
  parameter int unsigned PM_W     = 3,
  parameter int unsigned AM_CNT_W = 7,
  parameter int unsigned AM_PEAK  = 105,
  parameter int unsigned AM_SHIFT = 3,
  parameter int unsigned AM_W     = 4
) (
  input  logic                  emuclk_i,
  input  logic                  rst_i,
  ikaopll_lfo_gen_if.slave      bus
);

  localparam logic [AM_CNT_W-1:0] AmPeak  = AM_CNT_W'(AM_PEAK);
  localparam logic [AM_CNT_W-1:0] AmZero  = '0;
  localparam logic [AM_CNT_W-1:0] AmOne   = AM_CNT_W'(1);
  localparam logic [PRESC_W-1:0]  PrescOne = PRESC_W'(1);
  localparam logic [PM_DIV_W-1:0] DivOne   = PM_DIV_W'(1);
  localparam logic [PM_W-1:0]     PmOne    = PM_W'(1);

  logic [PRESC_W-1:0]  presc_q;
  logic [PM_DIV_W-1:0] pm_div_q;
  logic [PM_W-1:0]     pm_cnt_q;
  logic [AM_CNT_W-1:0] am_cnt_q, am_cnt_d;
  logic                am_dir_q, am_dir_d;  // 1 = counting down
  logic [AM_W-1:0]     amval_q, amval_d;

  logic                ce, tick, clr, carry, fast, step, pm_inc, latch;
  logic [PRESC_W-1:0]  presc_mask;
  logic [AM_CNT_W-1:0] am_shifted;

  logic unused_test;
  assign unused_test = ^{bus.test[0], bus.test[2]};

  always_comb begin
    ce    = ~bus.phi1_ncen_n;
    tick  = ce & bus.cycle_21;
    clr   = ce & (bus.test[1] | bus.sync);
    latch = ~bus.phi1_pcen_n & bus.cycle_00;
    // Higher rate_sel narrows the carry window to the low PRESC_W-r prescaler bits.
    presc_mask = {PRESC_W{1'b1}} >> bus.rate_sel;
    carry  = tick & ((presc_q & presc_mask) == presc_mask);
    fast   = tick & bus.test[3];
    step   = carry | fast;
    pm_inc = (carry & (&pm_div_q)) | fast;
  end

  // AM next state for one step.
  always_comb begin
    am_cnt_d = am_cnt_q;
    am_dir_d = am_dir_q;
    if (am_cnt_q > AmPeak) begin
      am_cnt_d = AmZero;
      am_dir_d = 1'b0;
    end else if (bus.am_mode) begin
      am_cnt_d = (am_cnt_q == AmPeak) ? AmZero : am_cnt_q + AmOne;
      am_dir_d = 1'b0;
    end else if (!am_dir_q) begin
      // Entering triangle at the peak (from sawtooth) turns straight around.
      if (am_cnt_q == AmPeak) begin
        am_cnt_d = am_cnt_q - AmOne;
        am_dir_d = 1'b1;
      end else begin
        am_cnt_d = am_cnt_q + AmOne;
        am_dir_d = (am_cnt_q + AmOne == AmPeak);
      end
    end else begin
      if (am_cnt_q == AmZero) begin
        am_cnt_d = AmOne;
        am_dir_d = 1'b0;
      end else begin
        am_cnt_d = am_cnt_q - AmOne;
        am_dir_d = ~(am_cnt_q == AmOne);
      end
    end
  end

  always_comb begin
    am_shifted = bus.am_deep ? (am_cnt_q >> AM_SHIFT) : (am_cnt_q >> (AM_SHIFT + 2));
    amval_d    = am_shifted[AM_W-1:0];
  end

  always_ff @(posedge emuclk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q  <= '0;
      pm_div_q <= '0;
      pm_cnt_q <= '0;
      am_cnt_q <= '0;
      am_dir_q <= 1'b0;
      amval_q  <= '0;
    end else begin
      if (clr) begin
        presc_q  <= '0;
        pm_div_q <= '0;
        pm_cnt_q <= '0;
        am_cnt_q <= '0;
        am_dir_q <= 1'b0;
      end else begin
        if (tick)   presc_q  <= presc_q + PrescOne;
        if (carry)  pm_div_q <= pm_div_q + DivOne;
        if (pm_inc) pm_cnt_q <= pm_cnt_q + PmOne;
        if (step) begin
          am_cnt_q <= am_cnt_d;
          am_dir_q <= am_dir_d;
        end
      end
      // Samples the pre-update counter; unaffected by clear.
      if (latch) amval_q <= amval_d;
    end
  end

  assign bus.pmval = pm_cnt_q;
  assign bus.amval = amval_q;

endmodule
